// File: rtl/ceespu_execute_mc.sv
// ceespu execute stage: ALU, branch resolution, store lane formatting and an
// iterative multiply/divide unit that is built only when CEESPU_MULDIV_EN is defined.
module ceespu_execute_mc #(
    parameter int XLEN = 32,
    parameter int PC_W = 14,
    localparam int NB  = XLEN / 8
) (
    input  logic            I_clk,
    input  logic            I_rst,
    input  logic            I_valid,
    input  logic            I_flush,
    input  logic [3:0]      I_aluop,
    input  logic [1:0]      I_selCin,
    input  logic [XLEN-1:0] I_dataA,
    input  logic [XLEN-1:0] I_dataB,
    input  logic [XLEN-1:0] I_storeData,
    input  logic            I_we,
    input  logic            I_memE,
    input  logic            I_memWe,
    input  logic [1:0]      I_selWb,
    input  logic [2:0]      I_selMem,
    input  logic [4:0]      I_regD,
    input  logic            I_isBranch,
    input  logic            I_prediction,
    input  logic [2:0]      I_branchop,
    input  logic [PC_W-1:0] I_PC,
    input  logic [PC_W-1:0] I_branchTarget,
    output logic            O_busy,
    output logic            O_branch_mispredict,
    output logic            O_branch_taken,
    output logic [PC_W-1:0] O_branchTarget,
    output logic [XLEN-1:0] O_memAddress,
    output logic [NB-1:0]   O_memWe,
    output logic [XLEN-1:0] O_StoreData,
    output logic            O_memE,
    output logic            O_we,
    output logic [XLEN-1:0] O_aluResult,
    output logic [1:0]      O_selWb,
    output logic [2:0]      O_selMem,
    output logic [PC_W-1:0] O_PC,
    output logic [4:0]      O_regD
);
    localparam int SH_W = $clog2(XLEN);
    localparam int LNB  = $clog2(NB);

    logic            carry;
    logic            cin;
    logic            accept;
    logic [XLEN-1:0] b_eff;
    logic [XLEN:0]   add_full;
    logic [SH_W-1:0] shamt;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] md_res;
    logic [LNB-1:0]  byte_sh, half_sh, word_sh;
    logic [NB-1:0]   lane_we;

    assign accept = I_valid & ~O_busy & ~I_flush;
    assign shamt  = I_dataB[SH_W-1:0];

    always_comb begin
        cin = 1'b0;
        case (I_selCin)
            2'd0: cin = 1'b0;
            2'd1: cin = carry;
            2'd2: cin = ~carry;
            default: cin = 1'b1;
        endcase
    end

    assign b_eff        = (I_aluop == 4'd1) ? ~I_dataB : I_dataB;
    assign add_full     = {1'b0, I_dataA} + {1'b0, b_eff} + {{XLEN{1'b0}}, cin};
    assign O_memAddress = add_full[XLEN-1:0];

    always_comb begin
        alu_res = I_dataB;
        case (I_aluop)
            4'd0, 4'd1:             alu_res = add_full[XLEN-1:0];
            4'd2:                   alu_res = I_dataA & I_dataB;
            4'd3:                   alu_res = I_dataA | I_dataB;
            4'd4:                   alu_res = I_dataA ^ I_dataB;
            4'd5:                   alu_res = I_dataA << shamt;
            4'd6:                   alu_res = I_dataA >> shamt;
            4'd7:                   alu_res = $unsigned($signed(I_dataA) >>> shamt);
            4'd8, 4'd9, 4'd10, 4'd11: alu_res = md_res;
            4'd12: alu_res = {{(XLEN-1){1'b0}}, ($signed(I_dataA) < $signed(I_dataB))};
            4'd13: alu_res = {{(XLEN-1){1'b0}}, (I_dataA < I_dataB)};
            default:                alu_res = I_dataB;
        endcase
    end

    always_comb begin
        O_branch_taken = 1'b1;
        case (I_branchop)
            3'd0: O_branch_taken = (I_dataA == I_dataB);
            3'd1: O_branch_taken = (I_dataA != I_dataB);
            3'd2: O_branch_taken = ($signed(I_dataA) < $signed(I_dataB));
            3'd3: O_branch_taken = ($signed(I_dataA) >= $signed(I_dataB));
            3'd4: O_branch_taken = (I_dataA < I_dataB);
            3'd5: O_branch_taken = (I_dataA >= I_dataB);
            3'd6: O_branch_taken = carry;
            default: O_branch_taken = 1'b1;
        endcase
    end

    assign O_branch_mispredict = I_valid & I_isBranch & (O_branch_taken != I_prediction);
    assign O_branchTarget      = I_prediction ? I_PC : I_branchTarget;
    assign O_memE              = I_memE & I_valid;

    // Lane offsets are aligned down to the access size; word32 offset collapses to 0 on XLEN=32.
    assign byte_sh = O_memAddress[LNB-1:0];
    assign half_sh = {O_memAddress[LNB-1:1], 1'b0};
    assign word_sh = LNB'({O_memAddress[2], 2'b00});

    always_comb begin
        O_StoreData = I_storeData;
        lane_we     = '1;
        case (I_selMem[1:0])
            2'd1: begin
                O_StoreData = {(NB/2){I_storeData[15:0]}};
                lane_we     = NB'(2'b11) << half_sh;
            end
            2'd2: begin
                O_StoreData = {NB{I_storeData[7:0]}};
                lane_we     = NB'(1'b1) << byte_sh;
            end
            2'd3: begin
                O_StoreData = {(XLEN/32){I_storeData[31:0]}};
                lane_we     = NB'(4'hF) << word_sh;
            end
            default: begin
                O_StoreData = I_storeData;
                lane_we     = '1;
            end
        endcase
    end

    assign O_memWe = (I_valid & I_memE & I_memWe) ? lane_we : '0;

    // Stage boundary: execute -> memory
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            carry       <= 1'b0;
            O_we        <= 1'b0;
            O_aluResult <= '0;
            O_selWb     <= '0;
            O_selMem    <= '0;
            O_PC        <= '0;
            O_regD      <= '0;
        end else begin
            if (accept && (I_aluop[3:1] == 3'b000))
                carry <= add_full[XLEN];
            O_we        <= accept & I_we;
            O_aluResult <= alu_res;
            O_selWb     <= I_selWb;
            O_selMem    <= I_selMem;
            O_PC        <= I_PC;
            O_regD      <= I_regD;
        end
    end

`ifdef CEESPU_MULDIV_EN
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} md_state_t;

    md_state_t       state;
    logic [SH_W-1:0] cnt;
    logic [XLEN-1:0] md_hi, md_lo, md_b;
    logic            md_div;
    logic            is_md;
    logic [XLEN:0]   mul_sum, div_shift, div_trial;

    assign is_md     = (I_aluop[3:2] == 2'b10);
    assign O_busy    = ((state == S_IDLE) & I_valid & is_md) | (state == S_BUSY);
    assign md_res    = (state == S_DONE) ? (I_aluop[0] ? md_hi : md_lo) : '0;
    assign mul_sum   = {1'b0, md_hi} + (md_lo[0] ? {1'b0, md_b} : {(XLEN+1){1'b0}});
    assign div_shift = {md_hi, md_lo[XLEN-1]};
    assign div_trial = div_shift - {1'b0, md_b};

    // hi:lo is the product for multiply and remainder:quotient for divide
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else if (I_flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (I_valid && is_md) begin
                    state  <= S_BUSY;
                    cnt    <= SH_W'(XLEN - 1);
                    md_div <= I_aluop[1];
                    md_hi  <= '0;
                    md_lo  <= I_aluop[1] ? I_dataA : I_dataB;
                    md_b   <= I_aluop[1] ? I_dataB : I_dataA;
                end
                S_BUSY: begin
                    if (md_div) begin
                        md_hi <= div_trial[XLEN] ? div_shift[XLEN-1:0] : div_trial[XLEN-1:0];
                        md_lo <= {md_lo[XLEN-2:0], ~div_trial[XLEN]};
                    end else begin
                        md_hi <= mul_sum[XLEN:1];
                        md_lo <= {mul_sum[0], md_lo[XLEN-1:1]};
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == '0)
                        state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
`else
    assign O_busy = 1'b0;
    assign md_res = '0;
`endif

endmodule

// File: tb/tb_ceespu_execute_mc.sv
// Self-checking bench for ceespu_execute_mc: directed vector table, hand-written
// mul/div and flush/reset sequences, and randomized ops against a reference model.
`timescale 1ns/1ps
module tb_ceespu_execute_mc;
    localparam int XLEN = 32;
    localparam int PC_W = 14;

    logic I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    logic        rst, valid, flush, we, meme, memwe, isbr, pred;
    logic [3:0]  aluop;
    logic [1:0]  selcin, selwb;
    logic [2:0]  selmem, brop;
    logic [4:0]  regd;
    logic [31:0] a, b, sd;
    logic [13:0] pc, btgt;

    logic        busy, mispred, taken, meme_o, owe;
    logic [13:0] otgt, opc;
    logic [31:0] maddr, osd, ores;
    logic [3:0]  mwe;
    logic [1:0]  oselwb;
    logic [2:0]  oselmem;
    logic [4:0]  oregd;

    logic        vld64, meme64, memwe64;
    logic [2:0]  selmem64;
    logic [63:0] a64, b64, sd64;
    logic        busy64, mispred64, taken64, meme64_o, owe64;
    logic [13:0] otgt64, opc64;
    logic [63:0] maddr64, osd64, ores64;
    logic [7:0]  mwe64;
    logic [1:0]  oselwb64;
    logic [2:0]  oselmem64;
    logic [4:0]  oregd64;

    int   n_vec = 0;
    int   n_err = 0;
    logic carry_m = 1'b0;

    ceespu_execute_mc #(.XLEN(32), .PC_W(PC_W)) u32 (
        .I_clk(I_clk), .I_rst(rst), .I_valid(valid), .I_flush(flush), .I_aluop(aluop),
        .I_selCin(selcin), .I_dataA(a), .I_dataB(b), .I_storeData(sd), .I_we(we),
        .I_memE(meme), .I_memWe(memwe), .I_selWb(selwb), .I_selMem(selmem), .I_regD(regd),
        .I_isBranch(isbr), .I_prediction(pred), .I_branchop(brop), .I_PC(pc),
        .I_branchTarget(btgt), .O_busy(busy), .O_branch_mispredict(mispred),
        .O_branch_taken(taken), .O_branchTarget(otgt), .O_memAddress(maddr), .O_memWe(mwe),
        .O_StoreData(osd), .O_memE(meme_o), .O_we(owe), .O_aluResult(ores), .O_selWb(oselwb),
        .O_selMem(oselmem), .O_PC(opc), .O_regD(oregd)
    );

    ceespu_execute_mc #(.XLEN(64), .PC_W(PC_W)) u64 (
        .I_clk(I_clk), .I_rst(rst), .I_valid(vld64), .I_flush(1'b0), .I_aluop(4'd0),
        .I_selCin(2'd0), .I_dataA(a64), .I_dataB(b64), .I_storeData(sd64), .I_we(1'b0),
        .I_memE(meme64), .I_memWe(memwe64), .I_selWb(2'd0), .I_selMem(selmem64), .I_regD(5'd0),
        .I_isBranch(1'b0), .I_prediction(1'b0), .I_branchop(3'd0), .I_PC(pc),
        .I_branchTarget(btgt), .O_busy(busy64), .O_branch_mispredict(mispred64),
        .O_branch_taken(taken64), .O_branchTarget(otgt64), .O_memAddress(maddr64), .O_memWe(mwe64),
        .O_StoreData(osd64), .O_memE(meme64_o), .O_we(owe64), .O_aluResult(ores64),
        .O_selWb(oselwb64), .O_selMem(oselmem64), .O_PC(opc64), .O_regD(oregd64)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: {carry_out, sum} of the shared adder
    function automatic logic [32:0] m_add(input logic [3:0] op, input logic [31:0] x, y, input logic c);
        logic [32:0] r;
        if (op == 4'd1) r = {1'b0, x} + 33'h0_FFFF_FFFF - y + c;
        else            r = {1'b0, x} + y + c;
        return r;
    endfunction

    function automatic logic [31:0] m_alu(input logic [3:0] op, input logic [31:0] x, y, input logic c);
        logic [63:0] p;
        int unsigned sh;
        sh = y % 32;
        p  = {32'b0, x} * {32'b0, y};
        case (op)
            4'd0:  return x + y + c;
            4'd1:  return x - y - 1 + c;
            4'd2:  return x & y;
            4'd3:  return x | y;
            4'd4:  return x ^ y;
            4'd5:  return x << sh;
            4'd6:  return x >> sh;
            4'd7:  return $signed(x) >>> sh;
            4'd8:  return p[31:0];
            4'd9:  return p[63:32];
            4'd10: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            4'd11: return (y == 0) ? x : x % y;
            4'd12: return {31'b0, $signed(x) < $signed(y)};
            4'd13: return {31'b0, x < y};
            default: return y;
        endcase
    endfunction

    function automatic logic m_br(input logic [2:0] op, input logic [31:0] x, y, input logic c);
        case (op)
            3'd0: return x == y;
            3'd1: return x != y;
            3'd2: return $signed(x) < $signed(y);
            3'd3: return $signed(x) >= $signed(y);
            3'd4: return x < y;
            3'd5: return x >= y;
            3'd6: return c;
            default: return 1'b1;
        endcase
    endfunction

    function automatic int m_size(input int nb, input logic [1:0] sel);
        return (sel == 2'd0) ? nb : (sel == 2'd1) ? 2 : (sel == 2'd2) ? 1 : 4;
    endfunction

    function automatic logic [63:0] m_we(input int nb, input logic [1:0] sel, input logic [63:0] addr, input logic en);
        int size, off;
        size = m_size(nb, sel);
        off  = (int'(addr % 64'(nb)) / size) * size;
        return en ? (((64'd1 << size) - 64'd1) << off) : 64'd0;
    endfunction

    function automatic logic [63:0] m_sd(input int nb, input logic [1:0] sel, input logic [63:0] d);
        int size;
        logic [63:0] unit, r;
        size = m_size(nb, sel);
        unit = (size == 8) ? d : (d & ((64'd1 << (8 * size)) - 64'd1));
        r = 64'd0;
        for (int i = 0; i < nb / size; i++) r = r | (unit << (8 * size * i));
        return r;
    endfunction

    typedef struct {
        logic [3:0]  op;
        logic [1:0]  sel;
        logic [31:0] x, y, res;
        logic        c;
    } vec_t;
    vec_t tbl[18];

`ifdef CEESPU_MULDIV_EN
    task automatic run_md(input logic [3:0] op, input logic [31:0] x, y, input string nm);
        logic [31:0] exp;
        int cyc;
        logic saw_we;
        exp = m_alu(op, x, y, 1'b0);
        cyc = 0;
        saw_we = 1'b0;
        aluop = op; a = x; b = y; valid = 1'b1; we = 1'b1; flush = 1'b0;
        #1;
        while (busy && cyc < 200) begin
            cyc++;
            @(posedge I_clk); #1;
            if (owe) saw_we = 1'b1;
        end
        chk({nm, "_busy_cycles"}, 64'(cyc), 64'(XLEN + 1));
        chk({nm, "_we_while_busy"}, {63'b0, saw_we}, 64'd0);
        @(posedge I_clk); #1;
        chk({nm, "_result"}, {32'b0, ores}, {32'b0, exp});
        chk({nm, "_we"}, {63'b0, owe}, 64'd1);
        valid = 1'b0; we = 1'b0;
    endtask
`endif

    initial begin
        logic [32:0] s;
        logic        t;
        rst = 1'b1; valid = 1'b1; flush = 1'b0; we = 1'b1; meme = 1'b0; memwe = 1'b0;
        isbr = 1'b0; pred = 1'b0; aluop = 4'd0; selcin = 2'd0; selwb = 2'd2; selmem = 3'd3;
        brop = 3'd6; regd = 5'd5; a = 32'd5; b = 32'd6; sd = 32'd0; pc = 14'h3; btgt = 14'h0;
        vld64 = 1'b0; meme64 = 1'b0; memwe64 = 1'b0; selmem64 = 3'd0;
        a64 = 64'd0; b64 = 64'd0; sd64 = 64'd0;

        // Reset state
        repeat (2) @(posedge I_clk);
        #1;
        chk("rst_we", {63'b0, owe}, 64'd0);
        chk("rst_result", {32'b0, ores}, 64'd0);
        chk("rst_pc", {50'b0, opc}, 64'd0);
        chk("rst_regd", {59'b0, oregd}, 64'd0);
        chk("rst_selwb", {62'b0, oselwb}, 64'd0);
        chk("rst_selmem", {61'b0, oselmem}, 64'd0);
        valid = 1'b0;
        #1;
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_carry", {63'b0, taken}, 64'd0);
        rst = 1'b0;
        @(posedge I_clk); #1;

        tbl[0]  = '{4'd0,  2'd0, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1};
        tbl[1]  = '{4'd0,  2'd1, 32'h0,         32'h0,         32'h1,         1'b0};
        tbl[2]  = '{4'd1,  2'd3, 32'h5,         32'h3,         32'h2,         1'b1};
        tbl[3]  = '{4'd2,  2'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b1};
        tbl[4]  = '{4'd4,  2'd0, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, 1'b1};
        tbl[5]  = '{4'd0,  2'd2, 32'h7,         32'h8,         32'hF,         1'b0};
        tbl[6]  = '{4'd1,  2'd3, 32'h3,         32'h5,         32'hFFFF_FFFE, 1'b0};
        tbl[7]  = '{4'd3,  2'd0, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1'b0};
        tbl[8]  = '{4'd5,  2'd0, 32'h1,         32'h21,        32'h2,         1'b0};
        tbl[9]  = '{4'd5,  2'd0, 32'h1,         32'h1F,        32'h8000_0000, 1'b0};
        tbl[10] = '{4'd6,  2'd0, 32'h8000_0000, 32'h4,         32'h0800_0000, 1'b0};
        tbl[11] = '{4'd7,  2'd0, 32'h8000_0000, 32'h4,         32'hF800_0000, 1'b0};
        tbl[12] = '{4'd12, 2'd0, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0};
        tbl[13] = '{4'd13, 2'd0, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0};
        tbl[14] = '{4'd14, 2'd0, 32'h0,         32'h1234_5678, 32'h1234_5678, 1'b0};
        tbl[15] = '{4'd15, 2'd0, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
        tbl[16] = '{4'd12, 2'd0, 32'h1,         32'hFFFF_FFFF, 32'h0,         1'b0};
        tbl[17] = '{4'd13, 2'd0, 32'h1,         32'hFFFF_FFFF, 32'h1,         1'b0};

        for (int i = 0; i < 18; i++) begin
            aluop = tbl[i].op; selcin = tbl[i].sel; a = tbl[i].x; b = tbl[i].y;
            valid = 1'b1; we = 1'b1; brop = 3'd6;
            @(posedge I_clk); #1;
            chk($sformatf("tbl%0d_result", i), {32'b0, ores}, {32'b0, tbl[i].res});
            chk($sformatf("tbl%0d_we", i), {63'b0, owe}, 64'd1);
            chk($sformatf("tbl%0d_carry", i), {63'b0, taken}, {63'b0, tbl[i].c});
            carry_m = tbl[i].c;
        end

        // Branch resolution
        aluop = 4'd2; we = 1'b0; a = 32'hFFFF_FFFF; b = 32'h1; brop = 3'd2; isbr = 1'b1;
        pred = 1'b0; pc = 14'h100; btgt = 14'h2A0;
        #1;
        chk("blt_taken", {63'b0, taken}, 64'd1);
        chk("blt_mispred_p0", {63'b0, mispred}, 64'd1);
        chk("blt_target_p0", {50'b0, otgt}, 64'h2A0);
        pred = 1'b1;
        #1;
        chk("blt_mispred_p1", {63'b0, mispred}, 64'd0);
        chk("blt_target_p1", {50'b0, otgt}, 64'h100);
        isbr = 1'b0; pred = 1'b0;

        // 64-bit store formatting
        vld64 = 1'b1; meme64 = 1'b1; memwe64 = 1'b1;
        a64 = 64'h1003; selmem64 = 3'd2; sd64 = 64'hAB;
        #1;
        chk("st64_byte_addr", maddr64, 64'h1003);
        chk("st64_byte_we", {56'b0, mwe64}, 64'h08);
        chk("st64_byte_data", osd64, 64'hABAB_ABAB_ABAB_ABAB);
        chk("st64_meme", {63'b0, meme64_o}, 64'd1);
        a64 = 64'h6; selmem64 = 3'd1; sd64 = 64'h1234_CDEF;
        #1;
        chk("st64_half_we", {56'b0, mwe64}, 64'hC0);
        chk("st64_half_data", osd64, 64'hCDEF_CDEF_CDEF_CDEF);
        a64 = 64'h4C; selmem64 = 3'd3; sd64 = 64'h5555_5555_8765_4321;
        #1;
        chk("st64_word_we", {56'b0, mwe64}, 64'hF0);
        chk("st64_word_data", osd64, 64'h8765_4321_8765_4321);
        selmem64 = 3'd0;
        #1;
        chk("st64_full_we", {56'b0, mwe64}, 64'hFF);
        chk("st64_full_data", osd64, 64'h5555_5555_8765_4321);
        memwe64 = 1'b0;
        #1;
        chk("st64_nowrite_we", {56'b0, mwe64}, 64'h00);
        memwe64 = 1'b1;
        for (int i = 0; i < 24; i++) begin
            a64 = {$urandom, $urandom}; b64 = 64'($urandom_range(0, 255));
            selmem64 = 3'($urandom_range(0, 3)); sd64 = {$urandom, $urandom};
            #1;
            chk("st64_rand_we", {56'b0, mwe64}, m_we(8, selmem64[1:0], a64 + b64, 1'b1));
            chk("st64_rand_data", osd64, m_sd(8, selmem64[1:0], sd64));
            chk("st64_rand_busy", {63'b0, busy64}, 64'd0);
        end
        @(posedge I_clk); #1;
        chk("st64_pc", {50'b0, opc64}, {50'b0, pc});
        chk("st64_we_reg", {63'b0, owe64}, 64'd0);

`ifdef CEESPU_MULDIV_EN
        // Flush on the fifth BUSY cycle of a divide
        aluop = 4'd10; a = 32'd1000; b = 32'd7; valid = 1'b1; we = 1'b1; flush = 1'b0;
        #1;
        chk("flush_busy_start", {63'b0, busy}, 64'd1);
        repeat (5) @(posedge I_clk);
        #1;
        chk("flush_busy_5th", {63'b0, busy}, 64'd1);
        flush = 1'b1;
        @(posedge I_clk); #1;
        flush = 1'b0; valid = 1'b0;
        #1;
        chk("flush_busy_after", {63'b0, busy}, 64'd0);
        chk("flush_we_after", {63'b0, owe}, 64'd0);

        // Flush coincident with a new multiply: the op must not start
        aluop = 4'd8; valid = 1'b1; flush = 1'b1;
        @(posedge I_clk); #1;
        valid = 1'b0; flush = 1'b0;
        #1;
        chk("flush_start_busy", {63'b0, busy}, 64'd0);
        chk("flush_start_we", {63'b0, owe}, 64'd0);

        run_md(4'd8,  32'h10000, 32'h10000, "mul");
        run_md(4'd9,  32'h10000, 32'h10000, "mulhu");
        run_md(4'd10, 32'd100, 32'd7, "divu");
        run_md(4'd11, 32'd100, 32'd7, "remu");
        run_md(4'd10, 32'h1234_5678, 32'd0, "divu_by0");
        run_md(4'd11, 32'd5, 32'd0, "remu_by0");
        for (int i = 0; i < 8; i++)
            run_md(4'(8 + (i % 4)), $urandom, (i < 4) ? $urandom : 32'($urandom_range(1, 300)), "md_rand");

        // Reset pulse in the middle of a multiply, with Carry set beforehand
        aluop = 4'd0; selcin = 2'd0; a = 32'hFFFF_FFFF; b = 32'h1; valid = 1'b1; we = 1'b1;
        @(posedge I_clk); #1;
        aluop = 4'd8; a = 32'd3; b = 32'd5; pc = 14'h1AB; regd = 5'd9;
        repeat (10) @(posedge I_clk);
        #1;
        rst = 1'b1; valid = 1'b0; brop = 3'd6;
        @(posedge I_clk); #1;
        chk("rstmid_busy", {63'b0, busy}, 64'd0);
        chk("rstmid_result", {32'b0, ores}, 64'd0);
        chk("rstmid_we", {63'b0, owe}, 64'd0);
        chk("rstmid_pc", {50'b0, opc}, 64'd0);
        chk("rstmid_regd", {59'b0, oregd}, 64'd0);
        chk("rstmid_carry", {63'b0, taken}, 64'd0);
        rst = 1'b0; carry_m = 1'b0;
        @(posedge I_clk); #1;
`else
        for (int i = 8; i < 12; i++) begin
            aluop = 4'(i); a = $urandom; b = $urandom; valid = 1'b1; we = 1'b1; flush = 1'b0;
            #1;
            chk($sformatf("md_off%0d_busy", i), {63'b0, busy}, 64'd0);
            @(posedge I_clk); #1;
            chk($sformatf("md_off%0d_result", i), {32'b0, ores}, 64'd0);
            chk($sformatf("md_off%0d_we", i), {63'b0, owe}, 64'd1);
        end
`endif

        // Randomized single-cycle traffic against the model
        for (int i = 0; i < 200; i++) begin
            int k;
            logic c_in, acc;
            k = int'($urandom_range(0, 11));
            aluop  = 4'((k < 8) ? k : k + 4);
            a      = $urandom;
            b      = ($urandom_range(0, 7) == 0) ? a : $urandom;
            sd     = $urandom;
            selcin = 2'($urandom_range(0, 3));
            valid  = ($urandom_range(0, 9) != 0);
            flush  = ($urandom_range(0, 9) == 0);
            we     = 1'($urandom_range(0, 1));
            meme   = 1'($urandom_range(0, 1));
            memwe  = 1'($urandom_range(0, 1));
            selmem = 3'($urandom_range(0, 2)) | (3'($urandom_range(0, 1)) << 2);
            brop   = 3'($urandom_range(0, 7));
            isbr   = 1'($urandom_range(0, 1));
            pred   = 1'($urandom_range(0, 1));
            pc     = 14'($urandom);
            btgt   = 14'($urandom);
            regd   = 5'($urandom);
            selwb  = 2'($urandom);
            #1;
            c_in = (selcin == 2'd0) ? 1'b0 : (selcin == 2'd1) ? carry_m :
                   (selcin == 2'd2) ? ~carry_m : 1'b1;
            s = m_add(aluop, a, b, c_in);
            t = m_br(brop, a, b, carry_m);
            chk("r_addr", {32'b0, maddr}, {32'b0, s[31:0]});
            chk("r_taken", {63'b0, taken}, {63'b0, t});
            chk("r_mispred", {63'b0, mispred}, {63'b0, valid & isbr & (t != pred)});
            chk("r_target", {50'b0, otgt}, {50'b0, pred ? pc : btgt});
            chk("r_memwe", {60'b0, mwe}, m_we(4, selmem[1:0], {32'b0, s[31:0]}, valid & meme & memwe));
            chk("r_stdata", {32'b0, osd}, m_sd(4, selmem[1:0], {32'b0, sd}));
            chk("r_meme", {63'b0, meme_o}, {63'b0, meme & valid});
            chk("r_busy", {63'b0, busy}, 64'd0);
            @(posedge I_clk); #1;
            acc = valid & ~flush;
            chk("r_result", {32'b0, ores}, {32'b0, m_alu(aluop, a, b, c_in)});
            chk("r_we", {63'b0, owe}, {63'b0, acc & we});
            chk("r_pc", {50'b0, opc}, {50'b0, pc});
            chk("r_regd", {59'b0, oregd}, {59'b0, regd});
            chk("r_selwb", {62'b0, oselwb}, {62'b0, selwb});
            chk("r_selmem", {61'b0, oselmem}, {61'b0, selmem});
            if (acc && aluop <= 4'd1) carry_m = s[32];
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ceespu_execute_mc.md
# ceespu_execute_mc

Parametrised execute stage for the ceespu pipeline. It sits between decode/operand-fetch and the memory stage. It runs single-cycle ALU ops, resolves branches and formats stores for XLEN/8 byte lanes. It also contains an iterative multiply/divide unit that stalls upstream through O_busy.

## Interface
Parameters:
- XLEN, 32 — datapath width; 32 or 64
- PC_W, 14 — PC / branch target width
- NB, XLEN/8 — byte lanes (derived, not overridden)

Ports:
- I_clk  in  1  clock; all state updates on rising edge
- I_rst  in  1  synchronous, active-high reset
- I_valid  in  1  instruction present this cycle
- I_flush  in  1  kill in-flight op (synchronous)
- I_aluop  in  4  ALU operation
- I_selCin  in  2  carry-in select: 0→0, 1→Carry, 2→!Carry, 3→1
- I_dataA, I_dataB, I_storeData  in  XLEN  operands, store data
- I_we, I_memE, I_memWe  in  1  writeback / mem enable / mem write
- I_selWb  in  2  writeback select (passed through)
- I_selMem  in  3  [1:0]: 0 full XLEN, 1 half, 2 byte, 3 word32 (XLEN=64 only)
- I_regD  in  5  destination register
- I_isBranch, I_prediction  in  1  branch flag, predicted-taken
- I_branchop  in  3  compare op
- I_PC, I_branchTarget  in  PC_W  next-instruction PC, decoded target
- O_busy  out  1  combinational stall request
- O_branch_mispredict, O_branch_taken  out  1  combinational
- O_branchTarget  out  PC_W  combinational: I_prediction ? I_PC : I_branchTarget
- O_memAddress  out  XLEN  combinational adder result
- O_memWe  out  NB  combinational byte-lane enables
- O_StoreData  out  XLEN  combinational replicated store data
- O_memE  out  1  combinational = I_memE & I_valid
- O_we, O_aluResult, O_selWb, O_selMem, O_PC, O_regD  out  registered stage outputs

## Operation
- Adder: A + (op==SUB ? ~B : B) + Cin. The Carry flag is updated from adder carry-out only on an accepted ADD/SUB (I_valid & !O_busy & !I_flush).
- aluop: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 MUL (low XLEN), 9 MULHU (high XLEN, unsigned), 10 DIVU, 11 REMU, 12 SLT, 13 SLTU, 14–15 pass B. Shift amount is B[log2(XLEN)-1:0].
- Mul/div FSM: IDLE → BUSY → DONE → IDLE.
  - IDLE: valid op 8–11 and !I_flush loads operands and counter=XLEN-1, then moves to BUSY.
  - BUSY: one shift-add / restoring-subtract step per cycle. Leaves for DONE when the counter reaches 0.
  - DONE: the result drives the ALU mux; stage registers capture it; FSM returns to IDLE.
- Divide by zero: DIVU → all ones; REMU → dividend.
- O_busy = (IDLE & I_valid & op∈8–11) | BUSY. It is low in DONE.
- branchop: 0 EQ, 1 NE, 2 LT, 3 GE (signed), 4 LTU, 5 GEU, 6 Carry==1, 7 always.
- O_branch_taken = compare result.
- O_branch_mispredict = I_valid & I_isBranch & (taken != I_prediction).
- Store data replication: byte → NB copies; half → NB/2 copies; word32 → 2 copies; full → unchanged.
- O_memWe (only when I_valid & I_memE & I_memWe, else 0). Low address bits below access size are ignored (aligned down).
  - byte: one-hot at addr[log2NB-1:0]
  - half: 2'b11 << 2·addr[log2NB-1:1]
  - word32: 4'hF << 4·addr[2]
  - full: all ones

## Timing
- Reset: all registered outputs 0, Carry 0, FSM IDLE, O_busy 0 the cycle after.
- Single-cycle op accepted at edge N: O_aluResult / O_we valid after edge N.
- Mul/div presented at cycle t: O_busy high for cycles t..t+XLEN and low at t+XLEN+1 (DONE). Result and O_we are registered at the end of t+XLEN+1. Total latency is XLEN+2 edges.
- Upstream must hold all inputs stable while O_busy=1.
- O_we register = I_valid & I_we & !O_busy & !I_flush. Other stage registers load every cycle.
- I_flush in any state: FSM → IDLE next edge, O_we=0, Carry unchanged.
- I_flush and a new mul/div in the same cycle: the op is not started.
- I_rst has priority over I_flush and over any FSM transition.

## Configuration
- CEESPU_MULDIV_EN defined: mul/div FSM present as above.
- Undefined: no FSM or datapath. Ops 8–11 give O_aluResult=0, complete in one cycle, and O_busy is constant 0.

## Test plan
- Reset then ADD A=0xFFFFFFFF, B=1, selCin=0 → O_aluResult=0, Carry=1. Next ADD 0+0 with selCin=1 → result 1.
- MUL A=0x10000, B=0x10000, XLEN=32 → O_busy high 33 cycles, then O_aluResult=0 and MULHU=1, O_we=1 one edge after DONE.
- DIVU 100/7 → 14; REMU → 2. DIVU x/0 → 0xFFFFFFFF; REMU 5/0 → 5.
- Byte store 0xAB, addr 0x1003, XLEN=64 → O_StoreData=0xABAB…AB, O_memWe=0x08. Half store at addr 6 → 0xC0.
- BLT A=-1, B=1, prediction=0 → taken=1, mispredict=1, O_branchTarget=I_branchTarget. With prediction=1 → mispredict=0, target=I_PC.
- I_flush on 5th BUSY cycle of DIVU → O_busy=0 next cycle, O_we=0. An I_rst pulse mid-MUL returns all outputs to 0.
